// File: rtl/l2_ctrl.sv
// L2 stream-buffer controller: per-stream prefetch bookkeeping, round-robin
// prefetch request arbitration, per-tile URAM read address generation.
module l2_ctrl #(
    parameter int nstrms          = 64,
    parameter int nstrms_width    = $clog2(nstrms),
    parameter int l2_ncl          = 256,
    parameter int l2_ncl_width    = $clog2(l2_ncl),
    parameter int l2_nstrms       = 16,
    parameter int l2_nstrms_width = $clog2(l2_nstrms),
    parameter int TILES           = nstrms / l2_nstrms
) (
    input  logic                                clk,
    input  logic                                reset,

    input  logic                                i_rst_v,
    output logic                                i_rst_r,
    input  logic [nstrms_width-1:0]             i_rst_sid,

    output logic [nstrms-1:0]                   o_rst_v,
    input  logic [nstrms-1:0]                   o_rst_r,

    input  logic [nstrms-1:0]                   i_rd_v,
    output logic [nstrms-1:0]                   i_rd_r,

    output logic [TILES-1:0]                    o_addr_v,
    input  logic [TILES-1:0]                    o_addr_r,
    output logic [TILES*l2_nstrms_width-1:0]    o_addr_sid,
    output logic [TILES*l2_ncl_width-1:0]       o_addr_ptr,

    output logic                                o_req_v,
    input  logic                                o_req_r,
    output logic [nstrms_width-1:0]             o_req_sid,

    input  logic                                i_rsp_v,
    output logic                                i_rsp_r,
    input  logic [nstrms_width-1:0]             i_rsp_sid
);

    localparam int SDEPTH = l2_ncl / l2_nstrms;
    localparam int SW     = $clog2(SDEPTH);
    localparam int CW     = SW + 1;

    logic [nstrms-1:0]      active;
    logic [nstrms-1:0]      rst_pend;
    logic [nstrms-1:0]      infl_zero;
    logic [nstrms-1:0]      want;
    logic [nstrms-1:0]      rd_cand;
    logic [nstrms-1:0]      rst_hit;
    logic [nstrms*SW-1:0]   rd_idx_all;

    logic                    rst_fire;
    logic                    rsp_fire;
    logic                    req_fire;
    logic                    req_found;
    logic [nstrms_width-1:0] rr_ptr;
    logic [nstrms_width-1:0] req_sid;

    // A stream may only be re-armed once L1 has seen its previous reset and
    // no prefetch for it is still outstanding.
    assign i_rst_r  = !reset & !rst_pend[i_rst_sid] & infl_zero[i_rst_sid];
    assign rst_fire = i_rst_v & i_rst_r;

    assign i_rsp_r  = !reset;
    assign rsp_fire = i_rsp_v & !reset;

    assign o_rst_v  = reset ? '0 : rst_pend;

    assign o_req_v   = |want;
    assign o_req_sid = req_sid;
    assign req_fire  = o_req_v & o_req_r;

    // Round-robin search starting at rr_ptr; index wraps naturally in nstrms_width bits.
    always_comb begin
        req_found = 1'b0;
        req_sid   = rr_ptr;
        for (int i = 0; i < nstrms; i++) begin
            if (!req_found && want[rr_ptr + nstrms_width'(i)]) begin
                req_found = 1'b1;
                req_sid   = rr_ptr + nstrms_width'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (req_fire) begin
            rr_ptr <= req_sid + nstrms_width'(1);
        end
    end

    for (genvar s = 0; s < nstrms; s++) begin : g_strm
        logic          active_q;
        logic          pend_q;
        logic [CW-1:0] filled;
        logic [CW-1:0] inflight;
        logic [SW-1:0] rd_idx;
        logic [CW:0]   occ;
        logic          req_hit;
        logic          rsp_hit;
        logic          rd_hit;

        assign rst_hit[s] = rst_fire & (i_rst_sid == nstrms_width'(s));
        assign req_hit    = req_fire & (req_sid == nstrms_width'(s));
        // Responses with nothing outstanding are dropped.
        assign rsp_hit    = rsp_fire & (i_rsp_sid == nstrms_width'(s)) & (inflight != '0);
        assign rd_hit     = i_rd_r[s];

        assign occ          = {1'b0, filled} + {1'b0, inflight};
        assign active[s]    = active_q;
        assign rst_pend[s]  = pend_q;
        assign infl_zero[s] = (inflight == '0);
        assign want[s]      = !reset & active_q & (occ < (CW+1)'(SDEPTH)) & !rst_hit[s];
        assign rd_cand[s]   = !reset & i_rd_v[s] & active_q & (filled != '0) & !rst_hit[s];
        assign rd_idx_all[s*SW +: SW] = rd_idx;

        always_ff @(posedge clk) begin
            if (reset) begin
                active_q <= 1'b0;
                pend_q   <= 1'b0;
                filled   <= '0;
                inflight <= '0;
                rd_idx   <= '0;
            end else if (rst_hit[s]) begin
                active_q <= 1'b1;
                pend_q   <= 1'b1;
                filled   <= '0;
                rd_idx   <= '0;
            end else begin
                filled   <= filled + CW'(rsp_hit) - CW'(rd_hit);
                inflight <= inflight + CW'(req_hit) - CW'(rsp_hit);
                if (rd_hit) begin
                    rd_idx <= rd_idx + SW'(1);
                end
                if (pend_q & o_rst_r[s]) begin
                    pend_q <= 1'b0;
                end
            end
        end
    end

    for (genvar t = 0; t < TILES; t++) begin : g_tile
        logic [l2_nstrms-1:0]       cand;
        logic [l2_nstrms-1:0]       gnt;
        logic [l2_nstrms_width-1:0] sel;
        logic [SW-1:0]              idx;

        assign cand = rd_cand[t*l2_nstrms +: l2_nstrms];
        // Isolate the lowest set bit: fixed priority to the lowest local id.
        assign gnt  = cand & (~cand + l2_nstrms'(1));

        always_comb begin
            sel = '0;
            idx = '0;
            for (int j = 0; j < l2_nstrms; j++) begin
                if (gnt[j]) begin
                    sel = l2_nstrms_width'(j);
                    idx = rd_idx_all[(t*l2_nstrms + j)*SW +: SW];
                end
            end
        end

        assign o_addr_v[t] = |cand;
        assign o_addr_sid[t*l2_nstrms_width +: l2_nstrms_width] = sel;
        assign o_addr_ptr[t*l2_ncl_width +: l2_ncl_width]       = {sel, idx};
        assign i_rd_r[t*l2_nstrms +: l2_nstrms] = gnt & {l2_nstrms{o_addr_r[t]}};
    end

endmodule

// File: tb/tb_l2_ctrl.sv
// Directed bench for l2_ctrl: prefetch requests are looped back as responses
// one cycle later; stream fills, arbitration order and read addresses are checked.
module tb_l2_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_rst_v;
    logic        i_rst_r;
    logic [5:0]  i_rst_sid;
    logic [63:0] o_rst_v;
    logic [63:0] o_rst_r;
    logic [63:0] i_rd_v;
    logic [63:0] i_rd_r;
    logic [3:0]  o_addr_v;
    logic [3:0]  o_addr_r;
    logic [15:0] o_addr_sid;
    logic [31:0] o_addr_ptr;
    logic        o_req_v;
    logic        o_req_r;
    logic [5:0]  o_req_sid;
    logic        i_rsp_v;
    logic        i_rsp_r;
    logic [5:0]  i_rsp_sid;

    int passed = 0;
    int total  = 0;
    logic loop_en = 1'b0;
    int req_cnt [64];
    int req_log [$];

    always #5 clk = ~clk;

    l2_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .i_rst_v    (i_rst_v),
        .i_rst_r    (i_rst_r),
        .i_rst_sid  (i_rst_sid),
        .o_rst_v    (o_rst_v),
        .o_rst_r    (o_rst_r),
        .i_rd_v     (i_rd_v),
        .i_rd_r     (i_rd_r),
        .o_addr_v   (o_addr_v),
        .o_addr_r   (o_addr_r),
        .o_addr_sid (o_addr_sid),
        .o_addr_ptr (o_addr_ptr),
        .o_req_v    (o_req_v),
        .o_req_r    (o_req_r),
        .o_req_sid  (o_req_sid),
        .i_rsp_v    (i_rsp_v),
        .i_rsp_r    (i_rsp_r),
        .i_rsp_sid  (i_rsp_sid)
    );

    // One-cycle memory model: every accepted request returns a line next cycle.
    always @(posedge clk) begin
        i_rsp_v   <= loop_en & o_req_v & o_req_r;
        i_rsp_sid <= o_req_sid;
    end

    always @(posedge clk) begin
        if (o_req_v && o_req_r) begin
            req_cnt[o_req_sid]++;
            req_log.push_back(int'(o_req_sid));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        for (int i = 0; i < 64; i++) req_cnt[i] = 0;
        req_log.delete();
    endtask

    task automatic chk_log(input int pos, input int exp);
        int v;
        v = (req_log.size() > pos) ? req_log[pos] : -1;
        chk($sformatf("arb_order[%0d]", pos), 64'(v), 64'(exp));
    endtask

    initial begin
        reset     = 1'b1;
        i_rst_v   = 1'b0;
        i_rst_sid = '0;
        o_rst_r   = '0;
        i_rd_v    = '0;
        o_addr_r  = '0;
        o_req_r   = 1'b0;
        clear_log();

        repeat (3) tick();
        #1;
        chk("rst_o_rst_v",  64'(o_rst_v),  64'h0);
        chk("rst_o_addr_v", 64'(o_addr_v), 64'h0);
        chk("rst_o_req_v",  64'(o_req_v),  64'h0);
        chk("rst_i_rst_r",  64'(i_rst_r),  64'h0);
        chk("rst_i_rsp_r",  64'(i_rsp_r),  64'h0);

        reset = 1'b0;
        #1;
        chk("idle_i_rst_r", 64'(i_rst_r), 64'h1);
        chk("idle_i_rsp_r", 64'(i_rsp_r), 64'h1);
        chk("idle_o_req_v", 64'(o_req_v), 64'h0);

        // Single stream reset and fill of stream 1.
        tick();
        loop_en   = 1'b1;
        o_req_r   = 1'b1;
        clear_log();
        i_rst_v   = 1'b1;
        i_rst_sid = 6'd1;
        #1;
        chk("s1_i_rst_r", 64'(i_rst_r), 64'h1);
        tick();
        i_rst_v = 1'b0;
        #1;
        chk("s1_o_rst_v",   o_rst_v,          64'h2);
        chk("s1_o_req_v",   64'(o_req_v),     64'h1);
        chk("s1_o_req_sid", 64'(o_req_sid),   64'h1);
        o_rst_r = '1;
        tick();
        chk("s1_o_rst_v_clr", o_rst_v, 64'h0);
        repeat (30) tick();
        chk("s1_req_cnt",    64'(req_cnt[1]),     64'd16);
        chk("s1_req_total",  64'(req_log.size()), 64'd16);
        chk("s1_full_req_v", 64'(o_req_v),        64'h0);

        // Back-to-back resets 1, 17, 2, 1 with L1 holding off reset acks.
        o_rst_r = '0;
        clear_log();
        i_rst_v   = 1'b1;
        i_rst_sid = 6'd1;
        #1;
        chk("b2b_r1", 64'(i_rst_r), 64'h1);
        tick();
        i_rst_sid = 6'd17;
        #1;
        chk("b2b_r17", 64'(i_rst_r), 64'h1);
        tick();
        i_rst_sid = 6'd2;
        #1;
        chk("b2b_r2", 64'(i_rst_r), 64'h1);
        tick();
        i_rst_sid = 6'd1;
        #1;
        chk("b2b_r1_again", 64'(i_rst_r), 64'h0);
        tick();
        i_rst_v = 1'b0;
        o_rst_r = ~64'h4;
        repeat (80) tick();
        chk_log(0, 1);
        chk_log(1, 17);
        chk_log(2, 1);
        chk_log(3, 2);
        chk_log(4, 17);
        chk_log(5, 1);
        chk("b2b_cnt1",   64'(req_cnt[1]),  64'd16);
        chk("b2b_cnt2",   64'(req_cnt[2]),  64'd16);
        chk("b2b_cnt17",  64'(req_cnt[17]), 64'd16);
        chk("b2b_req_v",  64'(o_req_v),     64'h0);

        // Two reads from stream 1, then two refill requests.
        clear_log();
        o_addr_r = 4'hF;
        i_rd_v   = 64'h2;
        #1;
        chk("rd1_addr_v", 64'(o_addr_v),         64'h1);
        chk("rd1_sid",    64'(o_addr_sid[3:0]),  64'h1);
        chk("rd1_ptr0",   64'(o_addr_ptr[7:0]),  64'h10);
        chk("rd1_rd_r0",  i_rd_r,                64'h2);
        tick();
        chk("rd1_ptr1",   64'(o_addr_ptr[7:0]),  64'h11);
        chk("rd1_rd_r1",  i_rd_r,                64'h2);
        tick();
        i_rd_v = '0;
        repeat (10) tick();
        chk("rd1_refill_cnt", 64'(req_cnt[1]),     64'd2);
        chk("rd1_refill_tot", 64'(req_log.size()), 64'd2);

        // Stream 17 read stalled by URAM ready on tile 1.
        o_addr_r = 4'b1101;
        i_rd_v   = 64'h0000_0000_0002_0000;
        #1;
        chk("rd17_addr_v",    64'(o_addr_v),          64'h2);
        chk("rd17_sid",       64'(o_addr_sid[7:4]),   64'h1);
        chk("rd17_ptr",       64'(o_addr_ptr[15:8]),  64'h10);
        chk("rd17_rd_r_stall", i_rd_r,                64'h0);
        tick();
        chk("rd17_ptr_held",  64'(o_addr_ptr[15:8]),  64'h10);
        chk("rd17_v_held",    64'(o_addr_v[1]),       64'h1);
        chk("rd17_rd_r_held", i_rd_r,                 64'h0);
        o_addr_r = 4'hF;
        #1;
        chk("rd17_rd_r_go",   i_rd_r, 64'h0000_0000_0002_0000);
        tick();
        i_rd_v = '0;
        #1;
        chk("rd17_idle_v",    64'(o_addr_v), 64'h0);

        // Stream 2 reset ack held off by L1.
        chk("s2_pend",        o_rst_v, 64'h4);
        i_rst_v   = 1'b1;
        i_rst_sid = 6'd2;
        #1;
        chk("s2_rst_blocked", 64'(i_rst_r), 64'h0);
        tick();
        chk("s2_pend_held",   o_rst_v, 64'h4);
        i_rst_v = 1'b0;
        o_rst_r = '1;
        tick();
        chk("s2_pend_clr",    o_rst_v, 64'h0);
        chk("s2_rst_ready",   64'(i_rst_r), 64'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
